// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin owner of the 4-digit BCD display with a minimum hold time
module seg_display_arbiter #(
  parameter int          TICK_DIV   = 1048576,
  parameter int          HOLD_TICKS = 4,
  parameter logic [15:0] IDLE_VALUE = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [15:0] val0,
  input  logic        req1,
  input  logic [15:0] val1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        busy,
  output logic [3:0]  d0,
  output logic [3:0]  d1,
  output logic [3:0]  d2,
  output logic [3:0]  d3
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHOW0 = 2'd1;
  localparam logic [1:0] SHOW1 = 2'd2;
  localparam int TW = $clog2(TICK_DIV);

  logic [TW-1:0] cnt;
  logic          tick;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [7:0]    hold;
  logic          ptr;
  logic          rel0;
  logic          rel1;
  logic          grant;
  logic [15:0]   src;

  function automatic logic [3:0] bcd(input logic [3:0] n);
    return n > 4'd9 ? 4'd0 : n;
  endfunction

  assign tick = cnt == TW'(TICK_DIV - 1);
  assign rel0 = hold == 8'd0 && (!req0 || req1);
  assign rel1 = hold == 8'd0 && (!req1 || req0);

  // ptr names the requester favoured on the next contended grant from IDLE
  always_comb begin
    state_nxt = state == SHOW0 ? (rel0 ? (req1 ? SHOW1 : IDLE) : SHOW0)
              : state == SHOW1 ? (rel1 ? (req0 ? SHOW0 : IDLE) : SHOW1)
              : (req0 && (!req1 || !ptr)) ? SHOW0
              : req1 ? SHOW1 : IDLE;
  end

  assign grant = state_nxt != state && state_nxt != IDLE;
  assign src   = state == SHOW0 ? val0 : state == SHOW1 ? val1 : IDLE_VALUE;
  assign gnt0  = state == SHOW0;
  assign gnt1  = state == SHOW1;
  assign busy  = gnt0 | gnt1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      state <= IDLE;
      hold  <= 8'd0;
      ptr   <= 1'b0;
      d0    <= 4'd0;
      d1    <= 4'd0;
      d2    <= 4'd0;
      d3    <= 4'd0;
    end else begin
      cnt   <= tick ? '0 : cnt + TW'(1);
      state <= state_nxt;
      if (grant) hold <= 8'(HOLD_TICKS);
      else if (tick && hold != 8'd0) hold <= hold - 8'd1;
      if (grant) ptr <= state_nxt == SHOW0;
      d0 <= bcd(src[15:12]);
      d1 <= bcd(src[11:8]);
      d2 <= bcd(src[7:4]);
      d3 <= bcd(src[3:0]);
    end
  end
endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter: directed checks of grant timing, round robin, hold and BCD clamp
module tb_seg_display_arbiter;
  logic        clk;
  logic        reset;
  logic        req0;
  logic        req1;
  logic [15:0] val0;
  logic [15:0] val1;
  logic        gnt0;
  logic        gnt1;
  logic        busy;
  logic [3:0]  d0;
  logic [3:0]  d1;
  logic [3:0]  d2;
  logic [3:0]  d3;
  logic [15:0] dig;
  int          total;
  int          bad;

  seg_display_arbiter #(.TICK_DIV(4), .HOLD_TICKS(2), .IDLE_VALUE(16'h0000)) dut (
    .clk(clk), .reset(reset), .req0(req0), .val0(val0), .req1(req1), .val1(val1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .d0(d0), .d1(d1), .d2(d2), .d3(d3)
  );

  assign dig = {d0, d1, d2, d3};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // the first posedge after this returns is edge 1; ticks then land on edges 4, 8, 12, ...
  task automatic rst_seq();
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    val0  = 16'h0000;
    val1  = 16'h0000;
    #12;
    reset = 1'b0;
    #1;
    chk("rst_gnt", {gnt0, gnt1, busy}, 3'b000);
    chk("rst_dig", dig, 16'h0000);
    reset = 1'b1;
    edges(3);
    chk("idle_gnt", {gnt0, gnt1, busy}, 3'b000);
    chk("idle_dig", dig, 16'h0000);

    req0 = 1'b1;
    val0 = 16'h1234;
    rst_seq();
    edges(1);
    chk("single_gnt", {gnt0, gnt1, busy}, 3'b101);
    chk("single_dig_lat", dig, 16'h0000);
    edges(1);
    chk("single_dig", dig, 16'h1234);
    val0 = 16'h5678;
    edges(1);
    chk("single_live", dig, 16'h5678);
    edges(5);
    chk("single_e8", {gnt0, gnt1}, 2'b10);
    req0 = 1'b0;
    edges(1);
    chk("single_rel", {gnt0, gnt1, busy}, 3'b000);
    chk("single_rel_dig", dig, 16'h5678);
    edges(1);
    chk("single_idle_dig", dig, 16'h0000);

    req0 = 1'b1;
    val0 = 16'h1234;
    val1 = 16'h9876;
    rst_seq();
    edges(1);
    chk("hold_e1", {gnt0, gnt1}, 2'b10);
    req1 = 1'b1;
    edges(7);
    chk("hold_e8", {gnt0, gnt1}, 2'b10);
    edges(1);
    chk("hold_switch", {gnt0, gnt1, busy}, 3'b011);
    chk("hold_switch_dig", dig, 16'h1234);
    edges(1);
    chk("hold_val1", dig, 16'h9876);
    edges(6);
    chk("rr_e16", {gnt0, gnt1}, 2'b01);
    edges(1);
    chk("rr_e17", {gnt0, gnt1}, 2'b10);
    edges(7);
    chk("rr_e24", {gnt0, gnt1}, 2'b10);
    edges(1);
    chk("rr_e25", {gnt0, gnt1}, 2'b01);
    req0 = 1'b0;
    req1 = 1'b0;
    edges(7);
    chk("rr_drain_e32", {gnt0, gnt1}, 2'b01);
    edges(1);
    chk("rr_idle_e33", {gnt0, gnt1, busy}, 3'b000);

    req0 = 1'b1;
    req1 = 1'b1;
    rst_seq();
    edges(1);
    chk("both_first", {gnt0, gnt1}, 2'b10);
    edges(8);
    chk("both_e9", {gnt0, gnt1}, 2'b01);
    edges(8);
    chk("both_e17", {gnt0, gnt1}, 2'b10);
    req0 = 1'b0;
    req1 = 1'b0;
    edges(8);
    chk("both_idle_e25", {gnt0, gnt1}, 2'b00);
    req0 = 1'b1;
    req1 = 1'b1;
    edges(1);
    chk("ptr_favours1", {gnt0, gnt1}, 2'b01);
    req0 = 1'b0;
    req1 = 1'b0;

    req1 = 1'b1;
    val1 = 16'h4321;
    rst_seq();
    edges(1);
    chk("early_gnt", {gnt0, gnt1}, 2'b01);
    req1 = 1'b0;
    edges(1);
    chk("early_kept", {gnt0, gnt1}, 2'b01);
    chk("early_dig", dig, 16'h4321);
    req1 = 1'b1;
    edges(6);
    chk("early_e8", {gnt0, gnt1}, 2'b01);
    edges(1);
    chk("early_stay", {gnt0, gnt1}, 2'b01);
    req1 = 1'b0;
    edges(1);
    chk("early_rel", {gnt0, gnt1, busy}, 3'b000);

    req1 = 1'b1;
    rst_seq();
    edges(1);
    req1 = 1'b0;
    edges(7);
    chk("drop_e8", {gnt0, gnt1}, 2'b01);
    edges(1);
    chk("drop_rel", {gnt0, gnt1}, 2'b00);

    req0 = 1'b1;
    val0 = 16'hA9F3;
    rst_seq();
    edges(2);
    chk("clamp_dig", dig, 16'h0903);
    reset = 1'b0;
    #2;
    chk("async_gnt", {gnt0, gnt1, busy}, 3'b000);
    chk("async_dig", dig, 16'h0000);
    reset = 1'b1;
    req0 = 1'b0;
    edges(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
